arm_mem_arbiter: RTL and testbench

Two-port to single-port memory arbiter for the ARM core, so the instruction-fetch side and the load/store side of `arm_processor` can share one unified single-port memory. Accepts one request at a time from either port, sequences the memory access (fixed read latency), and returns a one-cycle completion pulse with read data to the winning port. It sits between the processor's `PC`/`Instr` and `DataAdr`/`WriteData`/`ReadData` signals and the memory macro.

---
 rtl/arm_mem_arbiter_if.sv | 43 ++++
 rtl/arm_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_arm_mem_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/arm_mem_arbiter_if.sv
// arm_mem_arbiter_if: bundles the fetch port, data port and memory-side bus
// of the ARM two-port-to-one memory arbiter.
//
// Request/completion handshake (both CPU ports): a requester raises *_req with
// stable operands and keeps them stable until it samples *_done high; done is
// a single-cycle pulse and the requester drops req from the following cycle.
// The arbiter latches operands at grant, so later operand changes or an early
// req drop do not affect the transaction already in flight.
interface arm_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_done, i_rdata, d_done, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    // Requester / memory side
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_done, i_rdata, d_done, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/arm_mem_arbiter.sv
// arm_mem_arbiter: shares one single-port memory between the instruction-fetch
// and load/store ports of the ARM core. One transaction at a time, fixed read
// latency MEM_LAT (1..15), single-cycle done pulse to the owning port.
// Optional macro ARM_MEM_ARB_RR_EN selects round-robin arbitration on a tie;
// without it the data port has fixed priority over fetch.
// dbg_state exposes the FSM state (0 IDLE, 1 ACCESS, 2 WAIT, 3 DONE).
module arm_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    arm_mem_arbiter_if.slave    bus,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LAT4 = 4'(MEM_LAT);

    // Out-of-range latency would make the 4-bit counter wrap or never expire
    generate
        if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
            $error("arm_mem_arbiter: MEM_LAT=%0d outside legal range 1..15", MEM_LAT);
        end
    endgenerate

    state_t     state;
    logic [3:0] cnt;
    logic       own_d;    // 1 = data port owns the current transaction
    logic       grant_d;  // grant decision for the IDLE cycle

`ifdef ARM_MEM_ARB_RR_EN
    logic last_d;         // 1 = data port was served last

    // On a tie the port not served last wins; single requests always win
    always_comb begin
        grant_d = bus.d_req && (!bus.i_req || !last_d);
    end

    // Round-robin pointer, updated at grant, resets to "fetch last served"
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_d <= 1'b0;
        end else if (state == IDLE && (bus.i_req || bus.d_req)) begin
            last_d <= grant_d;
        end
    end
`else
    // Fixed priority: data beats fetch
    always_comb begin
        grant_d = bus.d_req;
    end
`endif

    assign dbg_state = state;

    // Main sequencer: grant, memory strobe, latency count, completion pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            own_d         <= 1'b0;
            bus.i_done    <= 1'b0;
            bus.i_rdata   <= '0;
            bus.d_done    <= 1'b0;
            bus.d_rdata   <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        own_d        <= grant_d;
                        bus.mem_we   <= grant_d && bus.d_we;
                        bus.mem_addr <= grant_d ? bus.d_addr : bus.i_addr;
                        if (grant_d) begin
                            bus.mem_wdata <= bus.d_wdata;
                        end
                        bus.mem_en   <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    bus.mem_en <= 1'b0;
                    if (bus.mem_we) begin
                        // Stores need no read wait; only the data port stores
                        bus.d_done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt   <= LAT4;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // cnt reaches 1 in the cycle where mem_rdata is valid
                    if (cnt == 4'd1) begin
                        if (own_d) begin
                            bus.d_rdata <= bus.mem_rdata;
                            bus.d_done  <= 1'b1;
                        end else begin
                            bus.i_rdata <= bus.mem_rdata;
                            bus.i_done  <= 1'b1;
                        end
                        cnt   <= 4'd0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    bus.i_done <= 1'b0;
                    bus.d_done <= 1'b0;
                    bus.busy   <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arm_mem_arbiter.sv
// tb_arm_mem_arbiter: directed bench for arm_mem_arbiter. Four instances cover
// MEM_LAT = 1, 2, 3 and 15. Inputs change and outputs are sampled on the
// falling edge; "cycle t" is the cycle in which a request is first presented.
module tb_arm_mem_arbiter;

    localparam logic [31:0] JUNK = 32'h0BAD_0BAD;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   tests  = 0;
    int   failed = 0;

    logic [1:0] dbg1, dbg2, dbg3, dbg15;

    arm_mem_arbiter_if if1 ();
    arm_mem_arbiter_if if2 ();
    arm_mem_arbiter_if if3 ();
    arm_mem_arbiter_if if15 ();

    arm_mem_arbiter #(.MEM_LAT(1))  u_dut1  (.clk(clk), .reset(reset), .bus(if1),  .dbg_state(dbg1));
    arm_mem_arbiter #(.MEM_LAT(2))  u_dut2  (.clk(clk), .reset(reset), .bus(if2),  .dbg_state(dbg2));
    arm_mem_arbiter #(.MEM_LAT(3))  u_dut3  (.clk(clk), .reset(reset), .bus(if3),  .dbg_state(dbg3));
    arm_mem_arbiter #(.MEM_LAT(15)) u_dut15 (.clk(clk), .reset(reset), .bus(if15), .dbg_state(dbg15));

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        logic [134:0] v;
        if1.i_req = 0;  if1.i_addr = '0;  if1.d_req = 0;  if1.d_we = 0;  if1.d_addr = '0;  if1.d_wdata = '0;  if1.mem_rdata = JUNK;
        if2.i_req = 0;  if2.i_addr = '0;  if2.d_req = 0;  if2.d_we = 0;  if2.d_addr = '0;  if2.d_wdata = '0;  if2.mem_rdata = JUNK;
        if3.i_req = 0;  if3.i_addr = '0;  if3.d_req = 0;  if3.d_we = 0;  if3.d_addr = '0;  if3.d_wdata = '0;  if3.mem_rdata = JUNK;
        if15.i_req = 0; if15.i_addr = '0; if15.d_req = 0; if15.d_we = 0; if15.d_addr = '0; if15.d_wdata = '0; if15.mem_rdata = JUNK;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        v = {if1.i_done, if1.d_done, if1.mem_en, if1.mem_we, if1.busy, dbg1,
             if1.mem_addr, if1.mem_wdata, if1.i_rdata, if1.d_rdata};
        tests++; if (v !== '0) begin failed++; $display("FAIL reset_lat1: got %h want 0", v); end
        v = {if2.i_done, if2.d_done, if2.mem_en, if2.mem_we, if2.busy, dbg2,
             if2.mem_addr, if2.mem_wdata, if2.i_rdata, if2.d_rdata};
        tests++; if (v !== '0) begin failed++; $display("FAIL reset_lat2: got %h want 0", v); end
        v = {if15.i_done, if15.d_done, if15.mem_en, if15.mem_we, if15.busy, dbg15,
             if15.mem_addr, if15.mem_wdata, if15.i_rdata, if15.d_rdata};
        tests++; if (v !== '0) begin failed++; $display("FAIL reset_lat15: got %h want 0", v); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        // cycle t
        if1.i_req = 1; if1.i_addr = 32'h0000_0010; if1.mem_rdata = JUNK;
        @(negedge clk); // t+1
        tests++; if (if1.mem_en !== 1'b1) begin failed++; $display("FAIL fetch_mem_en: got %b want 1", if1.mem_en); end
        tests++; if (if1.mem_we !== 1'b0) begin failed++; $display("FAIL fetch_mem_we: got %b want 0", if1.mem_we); end
        tests++; if (if1.mem_addr !== 32'h10) begin failed++; $display("FAIL fetch_mem_addr: got %h want 10", if1.mem_addr); end
        tests++; if (if1.busy !== 1'b1) begin failed++; $display("FAIL fetch_busy_rise: got %b want 1", if1.busy); end
        @(negedge clk); // t+2: memory data valid this cycle
        tests++; if (if1.i_done !== 1'b0) begin failed++; $display("FAIL fetch_early_done: got %b want 0", if1.i_done); end
        tests++; if (if1.mem_en !== 1'b0) begin failed++; $display("FAIL fetch_en_one_cycle: got %b want 0", if1.mem_en); end
        if1.mem_rdata = 32'hE3A0_1005;
        @(negedge clk); // t+3
        if1.mem_rdata = JUNK;
        tests++; if (if1.i_done !== 1'b1) begin failed++; $display("FAIL fetch_done: got %b want 1", if1.i_done); end
        tests++; if (if1.i_rdata !== 32'hE3A0_1005) begin failed++; $display("FAIL fetch_rdata: got %h want e3a01005", if1.i_rdata); end
        tests++; if (if1.d_done !== 1'b0) begin failed++; $display("FAIL fetch_no_d_done: got %b want 0", if1.d_done); end
        if1.i_req = 0;
        @(negedge clk); // t+4
        tests++; if (if1.busy !== 1'b0) begin failed++; $display("FAIL fetch_busy_fall: got %b want 0", if1.busy); end
        tests++; if (if1.i_done !== 1'b0) begin failed++; $display("FAIL fetch_done_pulse: got %b want 0", if1.i_done); end
        tests++; if (if1.i_rdata !== 32'hE3A0_1005) begin failed++; $display("FAIL fetch_rdata_hold: got %h want e3a01005", if1.i_rdata); end
    endtask

    task automatic test_store();
        if1.d_req = 1; if1.d_we = 1; if1.d_addr = 32'h64; if1.d_wdata = 32'h7;
        @(negedge clk); // t+1
        tests++; if ({if1.mem_en, if1.mem_we} !== 2'b11) begin failed++; $display("FAIL store_en_we: got %b want 11", {if1.mem_en, if1.mem_we}); end
        tests++; if (if1.mem_addr !== 32'h64) begin failed++; $display("FAIL store_addr: got %h want 64", if1.mem_addr); end
        tests++; if (if1.mem_wdata !== 32'h7) begin failed++; $display("FAIL store_wdata: got %h want 7", if1.mem_wdata); end
        @(negedge clk); // t+2
        tests++; if (if1.d_done !== 1'b1) begin failed++; $display("FAIL store_done: got %b want 1", if1.d_done); end
        tests++; if (if1.i_rdata !== 32'hE3A0_1005) begin failed++; $display("FAIL store_i_rdata_kept: got %h want e3a01005", if1.i_rdata); end
        tests++; if (if1.d_rdata !== 32'h0) begin failed++; $display("FAIL store_d_rdata_kept: got %h want 0", if1.d_rdata); end
        if1.d_req = 0; if1.d_we = 0;
        @(negedge clk); // t+3
        tests++; if ({if1.busy, if1.d_done, if1.mem_en} !== 3'b000) begin failed++; $display("FAIL store_idle: got %b want 000", {if1.busy, if1.d_done, if1.mem_en}); end
        tests++; if (if1.mem_we !== 1'b1) begin failed++; $display("FAIL store_we_hold: got %b want 1", if1.mem_we); end
    endtask

    task automatic test_early_drop();
        int en_cnt = 0;
        if1.d_req = 1; if1.d_we = 0; if1.d_addr = 32'h40;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            en_cnt += int'(if1.mem_en);
            tests++; if (if1.d_done !== (k == 3)) begin failed++; $display("FAIL drop_done_k%0d: got %b want %b", k, if1.d_done, (k == 3)); end
            if (k == 3) begin
                tests++; if (if1.d_rdata !== 32'hDEAD_BEEF) begin failed++; $display("FAIL drop_rdata: got %h want deadbeef", if1.d_rdata); end
            end
            if1.mem_rdata = (k == 2) ? 32'hDEAD_BEEF : JUNK;
            if (k == 1) if1.d_req = 0;
        end
        tests++; if (en_cnt != 1) begin failed++; $display("FAIL drop_single_en: got %0d want 1", en_cnt); end
    endtask

    task automatic test_priority();
        logic [3:0] order = 4'b0;
        int t_done [4];
        int n = 0;
        int cyc = 0;
`ifdef ARM_MEM_ARB_RR_EN
        logic [3:0]  exp_order = 4'b0101; // bit0 first: d, i, d, i
        logic [31:0] exp_irdata = 32'h1234_5678;
`else
        logic [3:0]  exp_order = 4'b1111;
        logic [31:0] exp_irdata = 32'h0;
`endif
        if2.mem_rdata = 32'h1234_5678;
        if2.d_we = 0; if2.d_addr = 32'h80; if2.i_addr = 32'h90;
        if2.d_req = 1; if2.i_req = 1;
        while (n < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (if2.d_done && if2.i_done) begin
                tests++; failed++; $display("FAIL prio_both_done: cycle %0d got 11 want one pulse", cyc);
            end
            if (if2.d_done || if2.i_done) begin
                order[n] = if2.d_done;
                t_done[n] = cyc;
                n++;
            end
        end
        if2.d_req = 0; if2.i_req = 0;
        tests++; if (n != 4) begin failed++; $display("FAIL prio_count: got %0d want 4", n); end
        tests++; if (order !== exp_order) begin failed++; $display("FAIL prio_order: got %b want %b", order, exp_order); end
        if (n == 4) begin
            tests++; if (t_done[0] != 4) begin failed++; $display("FAIL prio_first_done: got %0d want 4", t_done[0]); end
            for (int j = 1; j < 4; j++) begin
                tests++; if (t_done[j] - t_done[j-1] != 5) begin failed++; $display("FAIL prio_spacing%0d: got %0d want 5", j, t_done[j] - t_done[j-1]); end
            end
        end
        tests++; if (if2.d_rdata !== 32'h1234_5678) begin failed++; $display("FAIL prio_d_rdata: got %h want 12345678", if2.d_rdata); end
        tests++; if (if2.i_rdata !== exp_irdata) begin failed++; $display("FAIL prio_i_rdata: got %h want %h", if2.i_rdata, exp_irdata); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_lat15();
        if15.i_req = 1; if15.i_addr = 32'h100;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            tests++; if (if15.mem_en !== (k == 1)) begin failed++; $display("FAIL lat15_en_k%0d: got %b want %b", k, if15.mem_en, (k == 1)); end
            tests++; if (if15.i_done !== (k == 17)) begin failed++; $display("FAIL lat15_done_k%0d: got %b want %b", k, if15.i_done, (k == 17)); end
            if (k == 2) begin
                tests++; if (dbg15 !== 2'd2) begin failed++; $display("FAIL lat15_wait_state: got %0d want 2", dbg15); end
            end
            if (k == 16) begin
                tests++; if (if15.i_rdata !== 32'h0) begin failed++; $display("FAIL lat15_early_capture: got %h want 0", if15.i_rdata); end
            end
            if (k == 17) begin
                tests++; if (if15.i_rdata !== 32'hA5A5_0F0F) begin failed++; $display("FAIL lat15_rdata: got %h want a5a50f0f", if15.i_rdata); end
                if15.i_req = 0;
            end
            if (k == 18) begin
                tests++; if (if15.busy !== 1'b0) begin failed++; $display("FAIL lat15_busy_fall: got %b want 0", if15.busy); end
            end
            if15.mem_rdata = (k == 16) ? 32'hA5A5_0F0F : JUNK;
        end
    endtask

    task automatic test_async_reset();
        logic [134:0] v;
        int spurious = 0;
        if3.d_req = 1; if3.d_we = 0; if3.d_addr = 32'h20; if3.mem_rdata = JUNK;
        @(negedge clk); // t+1 ACCESS
        @(negedge clk); // t+2 WAIT
        tests++; if (dbg3 !== 2'd2) begin failed++; $display("FAIL arst_in_wait: got %0d want 2", dbg3); end
        #1 reset = 1'b0;
        if3.d_req = 0;
        #1;
        v = {if3.i_done, if3.d_done, if3.mem_en, if3.mem_we, if3.busy, dbg3,
             if3.mem_addr, if3.mem_wdata, if3.i_rdata, if3.d_rdata};
        tests++; if (v !== '0) begin failed++; $display("FAIL arst_immediate: got %h want 0", v); end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (if3.d_done !== 1'b0 || if3.mem_en !== 1'b0) spurious++;
        end
        tests++; if (spurious != 0) begin failed++; $display("FAIL arst_no_done: got %0d active cycles want 0", spurious); end
        // fresh load after release
        if3.d_req = 1; if3.d_addr = 32'h24;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            tests++; if (if3.d_done !== (k == 5)) begin failed++; $display("FAIL arst_fresh_done_k%0d: got %b want %b", k, if3.d_done, (k == 5)); end
            if (k == 5) begin
                tests++; if (if3.d_rdata !== 32'hCAFE_F00D) begin failed++; $display("FAIL arst_fresh_rdata: got %h want cafef00d", if3.d_rdata); end
                if3.d_req = 0;
            end
            if3.mem_rdata = (k == 4) ? 32'hCAFE_F00D : JUNK;
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_early_drop();
        test_priority();
        test_lat15();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
